mem_port_arbiter: RTL and testbench

// - Shares one single-ported unified memory between the core's instruction-fetch port and its load/store port.
// - Sits between the arm core (PC/Instr and ALUResult/WriteData/ReadData/MemWrite) and the external memory.
// - Returns a stall to the core while either port has an outstanding request.
// - Sequences variable-latency memory transactions with a per-transaction timeout.

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported memory between instruction-fetch and load/store ports.
// Define ARB_ROUND_ROBIN_EN to alternate grants on collisions; default is data-over-fetch priority.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          err,
  output logic          stall,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready
);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;

  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  grant_t        last_grant, grant_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          m_req_nxt, m_we_nxt, err_nxt;
  logic [AW-1:0] m_addr_nxt;
  logic [DW-1:0] m_wdata_nxt, i_rdata_nxt, d_rdata_nxt;
  logic          grant_d;

`ifdef ARB_ROUND_ROBIN_EN
  // On a collision the port that did not win last time goes first.
  assign grant_d = d_req & (~i_req | (last_grant == GRANT_I));
`else
  assign grant_d = d_req;
`endif

  assign i_ack = (state == DONE_I);
  assign d_ack = (state == DONE_D);
  assign stall = (i_req & ~i_ack) | (d_req & ~d_ack);

  // NOTE: every signal written here gets its hold value first so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    grant_nxt   = last_grant;
    cnt_nxt     = cnt;
    m_req_nxt   = m_req;
    m_we_nxt    = m_we;
    m_addr_nxt  = m_addr;
    m_wdata_nxt = m_wdata;
    i_rdata_nxt = i_rdata;
    d_rdata_nxt = d_rdata;
    err_nxt     = err;
    unique case (state)
      IDLE: begin
        if (grant_d) begin
          state_nxt   = BUSY_D;
          grant_nxt   = GRANT_D;
          cnt_nxt     = '0;
          m_req_nxt   = 1'b1;
          m_we_nxt    = d_we;
          m_addr_nxt  = d_addr;
          m_wdata_nxt = d_we ? d_wdata : '0;
        end else if (i_req) begin
          state_nxt   = BUSY_I;
          grant_nxt   = GRANT_I;
          cnt_nxt     = '0;
          m_req_nxt   = 1'b1;
          m_we_nxt    = 1'b0;
          m_addr_nxt  = i_addr;
          m_wdata_nxt = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        // A ready on the expiry cycle still wins over the abort.
        if (m_ready) begin
          m_req_nxt = 1'b0;
          if (state == BUSY_I) begin
            i_rdata_nxt = m_rdata;
            state_nxt   = DONE_I;
          end else begin
            d_rdata_nxt = m_rdata;
            state_nxt   = DONE_D;
          end
        end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
          m_req_nxt = 1'b0;
          err_nxt   = 1'b1;
          if (state == BUSY_I) begin
            i_rdata_nxt = '0;
            state_nxt   = DONE_I;
          end else begin
            d_rdata_nxt = '0;
            state_nxt   = DONE_D;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE_I, DONE_D: begin
        state_nxt = IDLE;
        err_nxt   = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      cnt        <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= grant_nxt;
      cnt        <= cnt_nxt;
      m_req      <= m_req_nxt;
      m_we       <= m_we_nxt;
      m_addr     <= m_addr_nxt;
      m_wdata    <= m_wdata_nxt;
      i_rdata    <= i_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
      err        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// transactions checked against a per-transaction reference model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_req, d_we, m_ready;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, m_rdata;
  logic [DW-1:0] i_rdata, d_rdata, m_wdata;
  logic [AW-1:0] m_addr;
  logic          i_ack, d_ack, err, stall, m_req, m_we;

  int n_checks = 0;
  int n_errors = 0;
  bit lg_d = 1'b0;  // model: last grant went to the data port

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .err(err), .stall(stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Arbitration rule: data wins collisions unless round-robin says fetch is due.
  function automatic bit pick_data(input bit ir, input bit dr, input bit last_d);
`ifdef ARB_ROUND_ROBIN_EN
    if (ir && dr) return !last_d;
`endif
    return dr;
  endfunction

  // Called at a negedge with the DUT in IDLE; returns at the negedge showing the ack.
  // wait_cycles: BUSY cycles without m_ready before it rises (-1 = never).
  task automatic txn(input string tag, input int wait_cycles, input logic [DW-1:0] rd,
                     input bit drop, output bit was_d);
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    logic          ewe;
    bit            ok;
    int            nb;
    was_d = pick_data(i_req, d_req, lg_d);
    ea    = was_d ? d_addr : i_addr;
    ewe   = was_d ? d_we : 1'b0;
    ew    = (was_d && d_we) ? d_wdata : '0;
    lg_d  = was_d;
    ok    = (wait_cycles >= 0) && (wait_cycles < TO);
    nb    = ok ? wait_cycles + 1 : TO;
    @(negedge clk);
    for (int k = 0; k < nb; k++) begin
      check({tag, " m_req"}, 32'(m_req), 32'd1);
      check({tag, " m_addr"}, m_addr, ea);
      check({tag, " m_we"}, 32'(m_we), 32'(ewe));
      check({tag, " m_wdata"}, m_wdata, ew);
      check({tag, " busy acks"}, {30'd0, i_ack, d_ack}, 32'd0);
      check({tag, " busy stall"}, 32'(stall), 32'(i_req | d_req));
      if (drop && k == 0) begin
        if (was_d) d_req = 1'b0; else i_req = 1'b0;
      end
      m_ready = (k == wait_cycles);
      m_rdata = (k == wait_cycles) ? rd : $urandom;
      @(negedge clk);
    end
    m_ready = 1'b0;
    check({tag, " i_ack"}, 32'(i_ack), 32'(!was_d));
    check({tag, " d_ack"}, 32'(d_ack), 32'(was_d));
    check({tag, " err"}, 32'(err), 32'(!ok));
    check({tag, " rdata"}, was_d ? d_rdata : i_rdata, ok ? rd : '0);
    check({tag, " m_req drop"}, 32'(m_req), 32'd0);
    check({tag, " ack stall"}, 32'(stall),
          32'((i_req & was_d) | (d_req & !was_d)));
  endtask

  // From the ack negedge to the following IDLE negedge; drives a stray m_ready.
  task automatic idle_step(input string tag);
    @(negedge clk);
    check({tag, " idle m_req"}, 32'(m_req), 32'd0);
    check({tag, " idle acks"}, {29'd0, i_ack, d_ack, err}, 32'd0);
    check({tag, " idle stall"}, 32'(stall), 32'(i_req | d_req));
    m_ready = 1'($urandom_range(0, 1));
  endtask

  initial begin
    bit w, w2;
    int r;
    reset = 1'b0;
    i_req = 0; d_req = 0; d_we = 0; m_ready = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst m_req", 32'(m_req), 32'd0);
    check("rst m_we", 32'(m_we), 32'd0);
    check("rst m_addr", m_addr, 32'd0);
    check("rst m_wdata", m_wdata, 32'd0);
    check("rst rdata", i_rdata | d_rdata, 32'd0);
    check("rst flags", {28'd0, i_ack, d_ack, err, stall}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Lone fetch with fastest memory response.
    i_req = 1; i_addr = 32'h0000_0040;
    txn("fetch", 0, 32'hE3A0_1005, 0, w);
    i_req = 0;
    idle_step("fetch");

    // Store completing on the fourth BUSY cycle.
    d_req = 1; d_we = 1; d_addr = 32'h64; d_wdata = 32'h7;
    txn("store", 3, 32'h1234_5678, 0, w);
    d_req = 0; d_we = 0;
    idle_step("store");

    // Collision: winner chosen by the model's arbitration rule, loser follows.
    i_req = 1; i_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h90;
    txn("coll1", 1, 32'hAAAA_0001, 0, w);
    if (w) d_req = 0; else i_req = 0;
    idle_step("coll1");
    txn("coll2", 0, 32'hAAAA_0002, 0, w2);
    check("coll2 other port", 32'(w2), 32'(!w));
    i_req = 0; d_req = 0;
    idle_step("coll2");

    // Timeout abort, then a ready on the very last allowed cycle.
    d_req = 1; d_we = 0; d_addr = 32'h200;
    txn("timeout", -1, 32'hDEAD_BEEF, 0, w);
    idle_step("timeout");
    txn("ready_at_limit", TO - 1, 32'h0BAD_F00D, 0, w);
    d_req = 0;
    idle_step("limit");

    // Back-to-back fetches with i_req held and stray m_ready in DONE/IDLE.
    i_req = 1; i_addr = 32'h40;
    txn("b2b1", 0, 32'h1111_1111, 0, w);
    i_addr = 32'h44; m_ready = 1;
    @(negedge clk);
    check("b2b idle m_req", 32'(m_req), 32'd0);
    check("b2b idle ack", {30'd0, i_ack, d_ack}, 32'd0);
    check("b2b idle stall", 32'(stall), 32'd1);
    txn("b2b2", 1, 32'h2222_2222, 0, w);
    i_req = 0;
    idle_step("b2b2");

    // Asynchronous reset in the middle of a BUSY phase.
    m_ready = 0;
    i_req = 1; i_addr = 32'h100;
    @(negedge clk);
    check("rstbusy m_req", 32'(m_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rstbusy m_req async", 32'(m_req), 32'd0);
    check("rstbusy no ack", {30'd0, i_ack, d_ack}, 32'd0);
    check("rstbusy stall", 32'(stall), 32'd1);
    @(negedge clk);
    check("rstbusy held", {29'd0, m_req, i_ack, d_ack}, 32'd0);
    reset = 1'b1;
    lg_d = 1'b0;
    txn("rst_restart", 0, 32'h3333_3333, 0, w);
    i_req = 0;
    idle_step("rst_restart");

    // Randomized transactions against the model.
    i_req = 1; i_addr = $urandom;
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 10));
      txn($sformatf("rnd%0d", n), (r == 10) ? -1 : r, $urandom,
          ($urandom_range(0, 3) == 0), w);
      if (w) begin
        d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
        d_addr = $urandom; d_wdata = $urandom;
      end else begin
        i_req = 1'($urandom_range(0, 1)); i_addr = $urandom;
      end
      if (!i_req && !d_req) begin
        if ($urandom_range(0, 1) == 1) begin i_req = 1; i_addr = $urandom; end
        else begin d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom; end
      end
      idle_step($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
